// File: rtl/output_stream_writer.sv
// AXI4-Stream writer: rescales/saturates accumulators into a pixel FIFO and frames one channel.
// Define OUT_RELU_EN to clamp negative pixels to zero at writeback.
module output_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int AXIS_WIDTH = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [7:0]            IMAGE_SIZE,
    input  logic [ACC_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  Busy,
    output logic                  Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_WIDTH-1:0] PMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] PMIN = ~PMAX;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [15:0] total_q, total_d;
    logic [15:0] count_q, count_d;
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0] head;
    logic fifo_empty, fifo_full, push, pop, last_px;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] pixel;

    assign shifted = $signed(in_data) >>> FRAC_SHIFT;

    always_comb begin
        if (shifted > PMAX) begin
            pixel = PMAX[DATA_WIDTH-1:0];
        end else if (shifted < PMIN) begin
            pixel = PMIN[DATA_WIDTH-1:0];
        end else begin
            pixel = shifted[DATA_WIDTH-1:0];
        end
`ifdef OUT_RELU_EN
        if (pixel[DATA_WIDTH-1]) pixel = '0;
`else
`endif
    end

    // Extra pointer bit distinguishes full from empty when indices match
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = !fifo_empty && head[DATA_WIDTH];
    assign m_axis_tdata  = fifo_empty ? '0 :
        {{(AXIS_WIDTH-DATA_WIDTH){head[DATA_WIDTH-1]}}, head[DATA_WIDTH-1:0]};

    assign push    = in_valid && in_ready;
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign last_px = (count_q == total_q - 16'd1);

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        count_d  = count_q;
        in_ready = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start && IMAGE_SIZE != 8'd0) begin
                    state_d = STREAM;
                    total_d = 16'(IMAGE_SIZE) * 16'(IMAGE_SIZE);
                    count_d = '0;
                end
            end
            STREAM: begin
                Busy     = 1'b1;
                in_ready = !fifo_full;
                if (in_valid && !fifo_full) begin
                    count_d = count_q + 16'd1;
                    if (last_px) state_d = DRAIN;
                end
            end
            DRAIN: begin
                Busy = 1'b1;
                if (pop && m_axis_tlast) state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            total_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {last_px, pixel};
    end

endmodule

// File: tb/tb_output_stream_writer.sv
// Directed bench for output_stream_writer: framing, saturation, backpressure, reset, ignored Starts.
// Honours OUT_RELU_EN when building expected pixels.
module tb_output_stream_writer;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [7:0]   IMAGE_SIZE = '0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         Busy;
    logic         Done;

`ifdef OUT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit rand_tready = 1'b0;
    logic [255:0] bq[$];
    bit lq[$];
    logic [15:0] exq[$];

    output_stream_writer dut (
        .clk(clk), .Reset(Reset), .Start(Start), .IMAGE_SIZE(IMAGE_SIZE),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            bq.push_back(m_axis_tdata);
            lq.push_back(m_axis_tlast);
        end
        if (Done) done_cnt++;
    end

    function automatic logic [255:0] sext(input logic [15:0] p);
        return {{240{p[15]}}, p};
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] p);
        return (RELU && p[15]) ? 16'h0000 : p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_tready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame(input logic [7:0] n);
        Start = 1'b1;
        IMAGE_SIZE = n;
        step();
        Start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input bit gaps);
        int t = 0;
        if (gaps) while ($urandom_range(0, 2) == 0) step();
        in_data = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 300) begin
            step();
            t++;
        end
        if (in_ready !== 1'b1) chk("push_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (Done !== 1'b1 && t < 1000) begin
            step();
            t++;
        end
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_busy_in_done"}, Busy, 0);
        step();
    endtask

    task automatic check_beats(input string tag, input int base);
        int n;
        n = exq.size();
        chk({tag, "_nbeats"}, 256'(bq.size() - base), 256'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < bq.size()) begin
                chk({tag, "_data"}, bq[base+i], sext(exq[i]));
                chk({tag, "_last"}, 256'(lq[base+i]), 256'(i == n - 1));
            end
        end
    endtask

    initial begin
        int base;
        int dbase;

        // reset state
        step();
        step();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        Reset = 1'b0;
        step();

        // 1: 4x4 frame, pixel k from k<<8
        m_axis_tready = 1'b1;
        base = bq.size();
        dbase = done_cnt;
        exq.delete();
        start_frame(8'd4);
        chk("t1_busy", Busy, 1);
        chk("t1_in_ready", in_ready, 1);
        for (int k = 0; k < 16; k++) begin
            push(32'(k) << 8, 1'b0);
            exq.push_back(16'(k));
        end
        wait_done("t1");
        check_beats("t1", base);
        chk("t1_done_once", 256'(done_cnt - dbase), 1);
        chk("t1_busy_after", Busy, 0);

        // 2: saturation, rounding toward -inf, sign extension
        base = bq.size();
        exq.delete();
        start_frame(8'd2);
        push(32'h7FFF_FFFF, 1'b0); exq.push_back(relu(16'h7FFF));
        push(32'h8000_0000, 1'b0); exq.push_back(relu(16'h8000));
        push(32'hFFFF_FF80, 1'b0); exq.push_back(relu(16'hFFFF));
        push(32'hFF80_0000, 1'b0); exq.push_back(relu(16'h8000));
        wait_done("t2");
        check_beats("t2", base);

        // 3: backpressure with 9 pixels into an 8-deep FIFO
        m_axis_tready = 1'b0;
        base = bq.size();
        exq.delete();
        start_frame(8'd3);
        push(32'(100) << 8, 1'b0);
        exq.push_back(16'd100);
        chk("t3_latency_tvalid", m_axis_tvalid, 1);
        chk("t3_latency_tdata", m_axis_tdata, sext(16'd100));
        for (int k = 1; k < 8; k++) begin
            push(32'(100 + k) << 8, 1'b0);
            exq.push_back(16'(100 + k));
        end
        chk("t3_full_in_ready", in_ready, 0);
        chk("t3_full_tvalid", m_axis_tvalid, 1);
        step();
        step();
        step();
        chk("t3_hold_tdata", m_axis_tdata, sext(16'd100));
        chk("t3_hold_tlast", m_axis_tlast, 0);
        chk("t3_hold_in_ready", in_ready, 0);
        chk("t3_no_beats", 256'(bq.size() - base), 0);
        m_axis_tready = 1'b1;
        push(32'(108) << 8, 1'b0);
        exq.push_back(16'd108);
        wait_done("t3");
        check_beats("t3", base);

        // 4: random tready and in_valid gaps, 8x8
        base = bq.size();
        dbase = done_cnt;
        exq.delete();
        rand_tready = 1'b1;
        start_frame(8'd8);
        for (int k = 0; k < 64; k++) begin
            push(32'(k) << 8, 1'b1);
            exq.push_back(16'(k));
        end
        wait_done("t4");
        rand_tready = 1'b0;
        m_axis_tready = 1'b1;
        check_beats("t4", base);
        chk("t4_done_once", 256'(done_cnt - dbase), 1);

        // 5: reset after 5 beats of a 4x4 frame
        m_axis_tready = 1'b0;
        base = bq.size();
        start_frame(8'd4);
        for (int k = 0; k < 8; k++) push(32'(k + 1) << 8, 1'b0);
        m_axis_tready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("t5_five_beats", 256'(bq.size() - base), 5);
        Reset = 1'b1;
        #1;
        chk("t5_rst_tvalid", m_axis_tvalid, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_busy", Busy, 0);
        chk("t5_rst_tlast", m_axis_tlast, 0);
        step();
        step();
        Reset = 1'b0;
        step();
        chk("t5_no_more_beats", 256'(bq.size() - base), 5);
        base = bq.size();
        dbase = done_cnt;
        exq.delete();
        start_frame(8'd2);
        for (int k = 0; k < 4; k++) begin
            push(32'(200 + k) << 8, 1'b0);
            exq.push_back(16'(200 + k));
        end
        wait_done("t5");
        check_beats("t5", base);
        chk("t5_done_once", 256'(done_cnt - dbase), 1);

        // 6: ignored Starts
        base = bq.size();
        dbase = done_cnt;
        start_frame(8'd0);
        step();
        step();
        chk("t6_zero_busy", Busy, 0);
        chk("t6_zero_in_ready", in_ready, 0);
        chk("t6_zero_no_done", 256'(done_cnt - dbase), 0);
        exq.delete();
        start_frame(8'd2);
        push(32'(50) << 8, 1'b0);
        exq.push_back(16'd50);
        start_frame(8'd1);
        chk("t6_restart_busy", Busy, 1);
        chk("t6_restart_in_ready", in_ready, 1);
        for (int k = 1; k < 4; k++) begin
            push(32'(50 + k) << 8, 1'b0);
            exq.push_back(16'(50 + k));
        end
        wait_done("t6");
        check_beats("t6", base);
        chk("t6_done_once", 256'(done_cnt - dbase), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
